// File: rtl/bus_addr_pkg.sv
// Shared opcode fields, subcommand codes and TX state encoding for the
// UART-debug bus address loader.
package bus_addr_pkg;

  localparam logic [1:0] PFX_LOAD   = 2'b10;
  localparam logic [1:0] PFX_SYS    = 2'b11;

  // SUB_PAGE is matched against opcode[5:4]; the others against opcode[5:0].
  localparam logic [1:0] SUB_PAGE   = 2'b00;
  localparam logic [5:0] SUB_CLEAR  = 6'b01_0000;
  localparam logic [5:0] SUB_INC    = 6'b01_0001;
  localparam logic [5:0] SUB_REPORT = 6'b10_0000;

  typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_e;

  function automatic int unsigned idx_width(input int unsigned nib);
    int unsigned w;
    w = $clog2(nib);
    return (w < 2) ? 2 : w;
  endfunction

endpackage

// File: rtl/tx_byte_issue.sv
// Byte issue engine: waits for the transmitter, fires one tx_en strobe per
// byte and inserts a low cycle between bytes.
module tx_byte_issue
  import bus_addr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       more,
  input  logic [7:0] byte_in,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       idle,
  output logic       byte_done
);

  tx_state_e st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      tx_en   <= 1'b0;
      tx_data <= '0;
    end else begin
      case (st)
        IDLE: begin
          tx_en <= 1'b0;
          if (start) st <= SEND;
        end
        SEND: begin
          if (!tx_busy) begin
            tx_en   <= 1'b1;
            tx_data <= byte_in;
            st      <= GAP;
          end
        end
        GAP: begin
          tx_en <= 1'b0;
          st    <= more ? SEND : IDLE;
        end
        default: begin
          tx_en <= 1'b0;
          st    <= IDLE;
        end
      endcase
    end
  end

  assign idle      = (st == IDLE);
  assign byte_done = (st == GAP);

endmodule

// File: rtl/bus_addr_loader.sv
// Command-driven bus address register: nibble loads with paging, clear,
// increment, bus-side auto-increment and MSB-first address read-back.
module bus_addr_loader
  import bus_addr_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter bit          ECHO   = 1'b1,
  parameter int unsigned STEP   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        opcode,
  input  logic              en,
  output logic              ready,
  output logic [7:0]        tx_data,
  output logic              tx_en,
  input  logic              tx_busy,
  input  logic              addr_inc,
  output logic [ADDR_W-1:0] addr
);

  localparam int unsigned       NIB       = ADDR_W / 4;
  localparam int unsigned       IDX_W     = idx_width(NIB);
  localparam int unsigned       PG_W      = IDX_W - 2;
  localparam int unsigned       NBYTES    = ADDR_W / 8;
  localparam logic [ADDR_W-1:0] STEP_V    = ADDR_W'(STEP);
  localparam logic [3:0]        LAST_BYTE = 4'(NBYTES - 1);

  logic              idle, byte_done, more, accept, byte_due;
  logic              is_load, is_page, is_clear, is_inc, is_report;
  logic [IDX_W-1:0]  nib_idx;
  logic [ADDR_W-1:0] load_val, snap;
  logic [3:0]        cnt;

  assign accept = en && idle;
  assign ready  = idle;
  assign more   = (cnt != '0);

  always_comb begin
    is_load   = (opcode[7:6] == PFX_LOAD);
    is_page   = (opcode[7:6] == PFX_SYS) && (opcode[5:4] == SUB_PAGE);
    is_clear  = (opcode[7:6] == PFX_SYS) && (opcode[5:0] == SUB_CLEAR);
    is_inc    = (opcode[7:6] == PFX_SYS) && (opcode[5:0] == SUB_INC);
    is_report = (opcode[7:6] == PFX_SYS) && (opcode[5:0] == SUB_REPORT);
    byte_due  = is_report || (ECHO && (is_load || is_page || is_clear || is_inc));
  end

  // Indices with no matching nibble leave load_val equal to addr.
  always_comb begin
    load_val = addr;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (nib_idx == IDX_W'(i)) load_val[i*4 +: 4] = opcode[3:0];
    end
  end

  if (PG_W > 0) begin : g_page
    logic [PG_W-1:0] page;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                page <= '0;
      else if (accept && is_page) page <= opcode[PG_W-1:0];
    end

    assign nib_idx = {page, opcode[5:4]};
  end else begin : g_flat
    assign nib_idx = opcode[5:4];
  end

  // An accepted LOAD/CLEAR/INC takes priority over a coincident addr_inc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  addr <= '0;
    else if (accept && is_load)  addr <= load_val;
    else if (accept && is_clear) addr <= '0;
    else if (accept && is_inc)   addr <= addr + STEP_V;
    else if (addr_inc)           addr <= addr + STEP_V;
  end

  // Echo bytes ride in the top byte of the same shift register as a report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap <= '0;
      cnt  <= '0;
    end else if (accept && byte_due) begin
      if (is_report) begin
        snap <= addr;
        cnt  <= LAST_BYTE;
      end else begin
        snap <= ADDR_W'(opcode) << (ADDR_W - 8);
        cnt  <= '0;
      end
    end else if (byte_done && more) begin
      snap <= snap << 8;
      cnt  <= cnt - 1'b1;
    end
  end

  tx_byte_issue u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept && byte_due),
    .more      (more),
    .byte_in   (snap[ADDR_W-1 -: 8]),
    .tx_busy   (tx_busy),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .idle      (idle),
    .byte_done (byte_done)
  );

endmodule

// File: tb/tb_bus_addr_loader.sv
// Bench for bus_addr_loader: a 16-bit and a 32-bit instance, directed
// scenarios plus a randomized run against a transaction-level model.
module tb_bus_addr_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_s [2];
  logic        inc_s [2];
  logic        busy_s [2];
  logic        ready_s [2];
  logic        tx_en_s [2];
  logic [7:0]  op_s [2];
  logic [7:0]  tx_data_s [2];
  logic [15:0] addr_a;
  logic [31:0] addr_b;

  int n_checks = 0;
  int n_fail   = 0;
  int gap_viol = 0;
  logic prev_en [2];

  logic [7:0]  obs0 [$];
  logic [7:0]  obs1 [$];
  logic [7:0]  exp1 [$];
  logic [31:0] m_addr;
  logic        m_page;

  always #5 clk = ~clk;

  bus_addr_loader #(.ADDR_W(16), .ECHO(1'b1), .STEP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(op_s[0]), .en(en_s[0]), .ready(ready_s[0]),
    .tx_data(tx_data_s[0]), .tx_en(tx_en_s[0]), .tx_busy(busy_s[0]),
    .addr_inc(inc_s[0]), .addr(addr_a)
  );

  bus_addr_loader #(.ADDR_W(32), .ECHO(1'b1), .STEP(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(op_s[1]), .en(en_s[1]), .ready(ready_s[1]),
    .tx_data(tx_data_s[1]), .tx_en(tx_en_s[1]), .tx_busy(busy_s[1]),
    .addr_inc(inc_s[1]), .addr(addr_b)
  );

  always @(negedge clk) begin
    if (tx_en_s[0]) obs0.push_back(tx_data_s[0]);
    if (tx_en_s[1]) obs1.push_back(tx_data_s[1]);
    for (int d = 0; d < 2; d++) begin
      if (tx_en_s[d] && prev_en[d]) gap_viol++;
      prev_en[d] = tx_en_s[d];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int d);
    int t = 0;
    while (!ready_s[d] && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!ready_s[d]) check("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic cmd(input int d, input logic [7:0] op, input logic inc);
    wait_ready(d);
    en_s[d]  = 1'b1;
    op_s[d]  = op;
    inc_s[d] = inc;
    @(negedge clk);
    en_s[d]  = 1'b0;
    inc_s[d] = 1'b0;
  endtask

  task automatic pop_check(input int d, input string tag, input logic [7:0] exp);
    logic [63:0] got;
    got = 64'h100;
    if (d == 0) begin
      if (obs0.size() > 0) got = 64'(obs0.pop_front());
    end else begin
      if (obs1.size() > 0) got = 64'(obs1.pop_front());
    end
    check(tag, got, 64'(exp));
  endtask

  task automatic load_a(input logic [15:0] v);
    for (int ii = 0; ii < 4; ii++) cmd(0, {2'b10, 2'(ii), v[ii*4 +: 4]}, 1'b0);
    wait_ready(0);
    obs0.delete();
  endtask

  task automatic load_b(input logic [31:0] v);
    for (int p = 0; p < 2; p++) begin
      cmd(1, {7'b1100_000, 1'(p)}, 1'b0);
      for (int ii = 0; ii < 4; ii++) cmd(1, {2'b10, 2'(ii), v[(p*4+ii)*4 +: 4]}, 1'b0);
    end
    wait_ready(1);
    obs1.delete();
  endtask

  // Reference behaviour of one accepted command on the 32-bit instance.
  task automatic model_cmd(input logic [7:0] op, input logic inc);
    logic wins = 1'b0;
    int   sh;
    if (op[7:6] == 2'b10) begin
      sh     = 4 * int'({m_page, op[5:4]});
      m_addr = (m_addr & ~(32'hF << sh)) | (32'(op[3:0]) << sh);
      exp1.push_back(op);
      wins = 1'b1;
    end else if (op[7:4] == 4'hC) begin
      m_page = op[0];
      exp1.push_back(op);
    end else if (op == 8'hD0) begin
      m_addr = 32'd0;
      exp1.push_back(op);
      wins = 1'b1;
    end else if (op == 8'hD1) begin
      m_addr = m_addr + 32'd1;
      exp1.push_back(op);
      wins = 1'b1;
    end else if (op == 8'hE0) begin
      for (int b = 3; b >= 0; b--) exp1.push_back(m_addr[b*8 +: 8]);
    end
    if (!wins && inc) m_addr = m_addr + 32'd1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    logic [7:0] op;
    logic inc, doen;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en_s[d] = 1'b0; inc_s[d] = 1'b0; busy_s[d] = 1'b0; op_s[d] = '0; prev_en[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_addr_a", addr_a, 0);
    check("rst_addr_b", addr_b, 0);
    check("rst_ready", ready_s[0], 1);
    check("rst_tx_en", tx_en_s[0], 0);
    check("rst_tx_data", tx_data_s[0], 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nibble loads on the 16-bit instance, with first-command timing.
    en_s[0] = 1'b1; op_s[0] = 8'h85;
    @(negedge clk);
    en_s[0] = 1'b0;
    check("t1_addr_k", addr_a, 16'h0005);
    check("t1_ready_low", ready_s[0], 0);
    check("t1_txen_k", tx_en_s[0], 0);
    @(negedge clk);
    check("t1_txen_k1", tx_en_s[0], 1);
    check("t1_txdata", tx_data_s[0], 8'h85);
    @(negedge clk);
    check("t1_txen_low", tx_en_s[0], 0);
    cmd(0, 8'h9A, 1'b0);
    cmd(0, 8'hA3, 1'b0);
    cmd(0, 8'hBC, 1'b0);
    wait_ready(0);
    check("t1_addr", addr_a, 16'hC3A5);
    pop_check(0, "t1_echo0", 8'h85);
    pop_check(0, "t1_echo1", 8'h9A);
    pop_check(0, "t1_echo2", 8'hA3);
    pop_check(0, "t1_echo3", 8'hBC);
    check("t1_echo_count", obs0.size(), 0);

    // Busy hold and dropped en.
    busy_s[0] = 1'b1;
    cmd(0, 8'h81, 1'b0);
    check("busy_ready_low", ready_s[0], 0);
    en_s[0] = 1'b1; op_s[0] = 8'h82;
    @(negedge clk);
    en_s[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_no_tx", obs0.size(), 0);
    check("busy_drop_addr", addr_a, 16'hC3A1);
    busy_s[0] = 1'b0;
    wait_ready(0);
    pop_check(0, "busy_echo", 8'h81);
    check("busy_one_byte", obs0.size(), 0);

    // Unknown byte.
    cmd(0, 8'h40, 1'b0);
    check("unk_ready", ready_s[0], 1);
    repeat (3) @(negedge clk);
    check("unk_no_tx", obs0.size(), 0);
    check("unk_addr", addr_a, 16'hC3A1);

    // Increment wrap and command priority over addr_inc.
    load_a(16'hFFFF);
    check("wrap_pre", addr_a, 16'hFFFF);
    cmd(0, 8'hD1, 1'b0);
    check("wrap_inc", addr_a, 16'h0000);
    wait_ready(0);
    pop_check(0, "wrap_echo", 8'hD1);
    cmd(0, 8'h85, 1'b0);
    wait_ready(0);
    obs0.delete();
    cmd(0, 8'hD0, 1'b1);
    check("clear_beats_inc", addr_a, 16'h0000);
    wait_ready(0);
    pop_check(0, "clear_echo", 8'hD0);
    load_a(16'hFFFF);
    inc_s[0] = 1'b1;
    @(negedge clk);
    inc_s[0] = 1'b0;
    check("addr_inc_wrap", addr_a, 16'h0000);

    // Paging on the 32-bit instance.
    cmd(1, 8'hC1, 1'b0);
    cmd(1, 8'h87, 1'b0);
    wait_ready(1);
    check("page_nibble", (addr_b >> 16) & 32'hF, 7);
    check("page_addr", addr_b, 32'h0007_0000);
    pop_check(1, "page_echo0", 8'hC1);
    pop_check(1, "page_echo1", 8'h87);

    // REPORT with addr_inc during transmission.
    load_b(32'h1234_5678);
    check("rep_pre", addr_b, 32'h1234_5678);
    cmd(1, 8'hE0, 1'b0);
    cyc = 0;
    while (!ready_s[1] && cyc < 100) begin
      @(negedge clk);
      cyc++;
      inc_s[1] = (cyc == 3);
    end
    inc_s[1] = 1'b0;
    check("rep_len", cyc, 8);
    check("rep_addr_after", addr_b, 32'h1234_5679);
    pop_check(1, "rep_b0", 8'h12);
    pop_check(1, "rep_b1", 8'h34);
    pop_check(1, "rep_b2", 8'h56);
    pop_check(1, "rep_b3", 8'h78);
    check("rep_count", obs1.size(), 0);

    // Reset aborting a REPORT before its second byte.
    cmd(1, 8'hE0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_tx_en", tx_en_s[1], 0);
    check("abort_addr", addr_b, 0);
    check("abort_ready", ready_s[1], 1);
    pop_check(1, "abort_b0", 8'h12);
    check("abort_count", obs1.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic against the model.
    m_addr = '0;
    m_page = 1'b0;
    exp1.delete();
    obs1.delete();
    for (int c = 0; c < 600; c++) begin
      if (c % 10 == 0) check("rnd_addr", addr_b, m_addr);
      busy_s[1] = ($urandom % 4 == 0);
      inc  = ($urandom % 4 == 0);
      doen = ready_s[1] && ($urandom % 3 == 0);
      case ($urandom % 6)
        0:       op = {2'b10, 6'($urandom)};
        1:       op = {4'hC, 4'($urandom)};
        2:       op = 8'hD0;
        3:       op = 8'hD1;
        4:       op = 8'hE0;
        default: op = 8'($urandom);
      endcase
      if (doen) model_cmd(op, inc);
      else if (inc) m_addr = m_addr + 32'd1;
      en_s[1] = doen; op_s[1] = op; inc_s[1] = inc;
      @(negedge clk);
    end
    en_s[1] = 1'b0; inc_s[1] = 1'b0; busy_s[1] = 1'b0;
    wait_ready(1);
    @(negedge clk);
    check("rnd_addr_final", addr_b, m_addr);
    check("rnd_tx_count", obs1.size(), exp1.size());
    for (int i = 0; i < exp1.size(); i++) pop_check(1, "rnd_tx", exp1[i]);

    check("tx_gap", gap_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
